sd_to_binary_converter: RTL and testbench

//  Converts a signed-digit (plus/minus vector) operand, as produced by the

---
 rtl/sd_to_binary_converter.sv | 116 +++++++++++
 tb/tb_sd_to_binary_converter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sd_to_binary_converter.sv
`default_nettype none
// ============================================================================
//  Module   : sd_to_binary_converter
//  Brief    : Folds MSB-first signed-digit chunks into a two's complement word.
//  Revision : 1.0  initial release
// ============================================================================
module sd_to_binary_converter #(
    parameter  int BITS   = 4,
    parameter  int CHUNKS = 4,
    localparam int OUT_W  = BITS * CHUNKS + 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BITS-1:0]  digit_plus,
    input  logic [BITS-1:0]  digit_minus,
    input  logic [1:0]       carry_in,
    input  logic             flush,
    output logic [OUT_W-1:0] result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             result_zero
);

    localparam int c_cnt_w = $clog2(CHUNKS + 1);
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(CHUNKS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    logic [OUT_W-1:0]   r_acc;
    logic [c_cnt_w-1:0] r_count;
    logic               r_in_ready;
    logic [OUT_W-1:0]   r_result;
    logic               r_result_valid;
    logic               r_result_zero;

    logic               w_accept;
    logic               w_last;
    logic [OUT_W-1:0]   w_chunk_val;
    logic [OUT_W-1:0]   w_carry_term;
    logic [OUT_W-1:0]   w_acc_base;
    logic [OUT_W-1:0]   w_acc_next;

    // Modular arithmetic at OUT_W bits gives the signed result directly.
    assign w_chunk_val  = OUT_W'(digit_plus) - OUT_W'(digit_minus);
    assign w_carry_term = (OUT_W'(carry_in[1]) - OUT_W'(carry_in[0])) << BITS;
    assign w_acc_base   = (r_state == S_IDLE) ? w_carry_term : (r_acc << BITS);
    assign w_acc_next   = w_acc_base + w_chunk_val;

    assign w_accept = in_valid & r_in_ready;
    assign w_last   = (r_state == S_IDLE) ? (CHUNKS == 1) : (r_count == c_last_cnt);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_acc          <= '0;
            r_count        <= '0;
            r_in_ready     <= 1'b1;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_result_zero  <= 1'b0;
        end else if (flush) begin
            r_state        <= S_IDLE;
            r_acc          <= '0;
            r_count        <= '0;
            r_in_ready     <= 1'b1;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_result_zero  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_ACCUM: begin
                    if (w_accept) begin
                        r_acc   <= w_acc_next;
                        r_count <= (r_state == S_IDLE) ? c_cnt_w'(1) : r_count + 1'b1;
                        if (w_last) begin
                            r_state        <= S_DONE;
                            r_in_ready     <= 1'b0;
                            r_result       <= w_acc_next;
                            r_result_valid <= 1'b1;
                            r_result_zero  <= (w_acc_next == '0);
                        end else begin
                            r_state <= S_ACCUM;
                        end
                    end
                end
                S_DONE: begin
                    if (result_ready) begin
                        r_state        <= S_IDLE;
                        r_acc          <= '0;
                        r_count        <= '0;
                        r_in_ready     <= 1'b1;
                        r_result_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready     = r_in_ready;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign result_zero  = r_result_zero;

endmodule
`default_nettype wire

// File: tb/tb_sd_to_binary_converter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sd_to_binary_converter
//  Brief    : Directed-vector bench for sd_to_binary_converter (4x4 digits).
//  Revision : 1.0  initial release
// ============================================================================
module tb_sd_to_binary_converter;

    localparam int BITS   = 4;
    localparam int CHUNKS = 4;
    localparam int OUT_W  = BITS * CHUNKS + 2;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [BITS-1:0]  digit_plus;
    logic [BITS-1:0]  digit_minus;
    logic [1:0]       carry_in;
    logic             flush;
    logic [OUT_W-1:0] result;
    logic             result_valid;
    logic             result_ready;
    logic             result_zero;

    int n_vec = 0;
    int n_err = 0;

    sd_to_binary_converter #(
        .BITS   (BITS),
        .CHUNKS (CHUNKS)
    ) u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .digit_plus   (digit_plus),
        .digit_minus  (digit_minus),
        .carry_in     (carry_in),
        .flush        (flush),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result_zero  (result_zero)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [3:0] p, input logic [3:0] m, input logic [1:0] c);
        digit_plus  = p;
        digit_minus = m;
        carry_in    = c;
        in_valid    = 1'b1;
        tick();
        in_valid    = 1'b0;
    endtask

    // Non-leading beats carry 2'b01 on carry_in, which must be ignored.
    task automatic run_operand(input logic [15:0] p16, input logic [15:0] m16, input logic [1:0] c);
        for (int i = 0; i < CHUNKS; i++)
            send_beat(p16[15-4*i -: 4], m16[15-4*i -: 4], (i == 0) ? c : 2'b01);
    endtask

    task automatic check_result(input string tag, input logic [17:0] exp_val, input logic exp_zero);
        check_eq({tag, "_valid"}, 32'(result_valid), 32'd1);
        check_eq({tag, "_value"}, 32'(result), 32'(exp_val));
        check_eq({tag, "_zero"},  32'(result_zero), 32'(exp_zero));
        check_eq({tag, "_ready"}, 32'(in_ready), 32'd0);
    endtask

    task automatic drain(input string tag);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check_eq({tag, "_drained"}, 32'(result_valid), 32'd0);
        check_eq({tag, "_idle_rdy"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        reset_n      = 1'b0;
        in_valid     = 1'b0;
        digit_plus   = '0;
        digit_minus  = '0;
        carry_in     = '0;
        flush        = 1'b0;
        result_ready = 1'b0;
        repeat (3) tick();
        check_eq("rst_result", 32'(result), 32'd0);
        check_eq("rst_valid",  32'(result_valid), 32'd0);
        check_eq("rst_zero",   32'(result_zero), 32'd0);
        reset_n = 1'b1;
        tick();
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);

        // All-positive maximum
        run_operand(16'hFFFF, 16'h0000, 2'b00);
        check_result("c1", 18'h0FFFF, 1'b0);
        drain("c1");

        // Most negative: -2^16 - 0xFFFF = -131071
        run_operand(16'h0000, 16'hFFFF, 2'b01);
        check_result("c2", 18'h20001, 1'b0);
        drain("c2");

        // Cancelling digits and cancelling carry
        run_operand(16'hA53C, 16'hA53C, 2'b11);
        check_result("c3", 18'h00000, 1'b1);
        drain("c3");

        // 1*4096 - 1*256 = 3840 with bubbles between beats
        send_beat(4'h1, 4'h0, 2'b00);
        tick();
        send_beat(4'h0, 4'h1, 2'b00);
        tick();
        tick();
        send_beat(4'h0, 4'h0, 2'b00);
        tick();
        check_eq("c4_not_early", 32'(result_valid), 32'd0);
        send_beat(4'h0, 4'h0, 2'b00);
        check_result("c4", 18'h00F00, 1'b0);

        // Back-pressure: result held, new chunks refused
        digit_plus  = 4'h7;
        digit_minus = 4'h0;
        in_valid    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("c5_hold_value", 32'(result), 32'h00F00);
            check_eq("c5_hold_valid", 32'(result_valid), 32'd1);
            check_eq("c5_hold_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        drain("c5");
        run_operand(16'hFFFF, 16'h0000, 2'b00);
        check_result("c5_next", 18'h0FFFF, 1'b0);
        drain("c5_next");

        // Async reset mid-operand
        send_beat(4'h3, 4'h0, 2'b01);
        send_beat(4'h3, 4'h0, 2'b00);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("c6r_result", 32'(result), 32'd0);
        check_eq("c6r_valid",  32'(result_valid), 32'd0);
        check_eq("c6r_zero",   32'(result_zero), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        run_operand(16'hFFFF, 16'h0000, 2'b00);
        check_result("c6r_next", 18'h0FFFF, 1'b0);

        // Flush while a result is pending discards it
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("c6f_done_valid",  32'(result_valid), 32'd0);
        check_eq("c6f_done_result", 32'(result), 32'd0);
        check_eq("c6f_done_ready",  32'(in_ready), 32'd1);

        // Flush after two beats, coinciding with a third accept (dropped)
        send_beat(4'h5, 4'h0, 2'b01);
        send_beat(4'h5, 4'h0, 2'b00);
        flush = 1'b1;
        send_beat(4'h5, 4'h0, 2'b00);
        flush = 1'b0;
        check_eq("c6f_valid", 32'(result_valid), 32'd0);
        check_eq("c6f_zero",  32'(result_zero), 32'd0);
        run_operand(16'hFFFF, 16'h0000, 2'b00);
        check_result("c6f_next", 18'h0FFFF, 1'b0);
        drain("c6f_next");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
